// File: rtl/ghost_pkg.sv
// ghost_pkg: definitions shared by the ghost scheduler, renderer and pellet logic.
//   - one-hot direction encodings (UP/DOWN/LEFT/RIGHT, NONE = no heading yet)
//   - scheduler FSM state enum
//   - default grid width and ghost start tile
//   - LFSR width, tap mask and helpers for candidate selection
package ghost_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_NEXT   = 2'd3
    } state_t;

    localparam int DEF_POS_W   = 5;
    localparam int DEF_START_X = 8;
    localparam int DEF_START_Y = 8;

    // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Direction index (0=UP,1=DOWN,2=LEFT,3=RIGHT) to one-hot.
    function automatic logic [3:0] dir_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // One-hot direction to index; only called with a nonzero direction.
    function automatic logic [1:0] dir_index(input logic [3:0] dir);
        case (dir)
            DIR_UP:   return 2'd0;
            DIR_DOWN: return 2'd1;
            DIR_LEFT: return 2'd2;
            default:  return 2'd3;
        endcase
    endfunction

    // First direction not yet tried, rotating from 'start'.
    function automatic logic [1:0] pick_untried(input logic [3:0] tried,
                                                input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && !tried[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ghost_scheduler_if.sv
// ghost_scheduler_if: maze wall-lookup port shared by all ghosts.
//   master (scheduler): maze_rd_req, maze_rd_x, maze_rd_y out; maze_rd_valid, maze_rd_wall in
//   slave  (maze ROM arbiter): the reverse
interface ghost_scheduler_if #(
    parameter int POS_W = ghost_pkg::DEF_POS_W
);
    logic             maze_rd_req;
    logic [POS_W-1:0] maze_rd_x;
    logic [POS_W-1:0] maze_rd_y;
    logic             maze_rd_valid;
    logic             maze_rd_wall;

    modport master (
        output maze_rd_req, maze_rd_x, maze_rd_y,
        input  maze_rd_valid, maze_rd_wall
    );

    modport slave (
        input  maze_rd_req, maze_rd_x, maze_rd_y,
        output maze_rd_valid, maze_rd_wall
    );
endinterface

// File: rtl/ghost_lfsr.sv
// ghost_lfsr: free-running 16-bit Fibonacci LFSR.
//   clk     system clock
//   rst     asynchronous active-low reset, loads SEED
//   i_en    advance enable
//   o_bits  low OUT_W bits of the LFSR state
module ghost_lfsr
    import ghost_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_bits
);
    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb   = ^(r_state & LFSR_TAPS);
    assign o_bits = r_state[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end
endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler: once per move_tick, walks every ghost through probe/decide,
// sharing one maze wall-lookup port.
//   clk, rst                     clock, asynchronous active-low reset
//   move_tick                    starts a movement round
//   maze (master)                wall lookup: req/x/y out, valid/wall in
//   ghost_x, ghost_y, ghost_dir  packed per-ghost position and one-hot heading
//   busy, round_done, tick_overrun  round status pulses/levels
module ghost_scheduler
    import ghost_pkg::*;
#(
    parameter int                NUM_GHOSTS = 4,
    parameter int                POS_W      = DEF_POS_W,
    parameter int                START_X    = DEF_START_X,
    parameter int                START_Y    = DEF_START_Y,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        move_tick,
    ghost_scheduler_if.master           maze,
    output logic [NUM_GHOSTS*POS_W-1:0] ghost_x,
    output logic [NUM_GHOSTS*POS_W-1:0] ghost_y,
    output logic [NUM_GHOSTS*4-1:0]     ghost_dir,
    output logic                        busy,
    output logic                        round_done,
    output logic                        tick_overrun
);
    localparam int              G_W    = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [G_W-1:0]  LAST_G = G_W'(NUM_GHOSTS - 1);

    state_t           r_state;
    logic [G_W-1:0]   r_g;
    logic [POS_W-1:0] r_x   [NUM_GHOSTS];
    logic [POS_W-1:0] r_y   [NUM_GHOSTS];
    logic [3:0]       r_dir [NUM_GHOSTS];
    logic [3:0]       r_tried;
    logic [1:0]       r_cand;
    logic             r_wall;
    logic             r_req;
    logic [POS_W-1:0] r_rd_x;
    logic [POS_W-1:0] r_rd_y;
    logic             r_busy;
    logic             r_done;
    logic             r_ovr;

    logic [1:0]       w_lfsr;
    logic [G_W-1:0]   w_sel_g;
    logic [G_W-1:0]   w_pos_g;
    logic [1:0]       w_cand;
    logic [POS_W-1:0] w_tx;
    logic [POS_W-1:0] w_ty;

    ghost_lfsr #(.SEED(LFSR_SEED), .OUT_W(2)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .o_bits (w_lfsr)
    );

    // Next probe: a fresh ghost (from IDLE or NEXT) starts with its heading,
    // or a random one if it has none; a retry from DECIDE rotates to an
    // untried direction starting at the current LFSR value.
    always_comb begin
        w_sel_g = '0;
        if (r_state == ST_NEXT && r_g != LAST_G) begin
            w_sel_g = r_g + 1'b1;
        end
        w_pos_g = (r_state == ST_DECIDE) ? r_g : w_sel_g;
        w_cand  = (r_dir[w_sel_g] != DIR_NONE) ? dir_index(r_dir[w_sel_g]) : w_lfsr;
        if (r_state == ST_DECIDE) begin
            w_cand = pick_untried(r_tried, w_lfsr);
        end
        w_tx = r_x[w_pos_g];
        w_ty = r_y[w_pos_g];
        case (w_cand)
            2'd0:    w_ty = r_y[w_pos_g] - 1'b1;   // UP
            2'd1:    w_ty = r_y[w_pos_g] + 1'b1;   // DOWN
            2'd2:    w_tx = r_x[w_pos_g] - 1'b1;   // LEFT
            default: w_tx = r_x[w_pos_g] + 1'b1;   // RIGHT
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_g     <= '0;
            r_tried <= '0;
            r_cand  <= '0;
            r_wall  <= 1'b0;
            r_req   <= 1'b0;
            r_rd_x  <= '0;
            r_rd_y  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_x[i]   <= POS_W'(START_X);
                r_y[i]   <= POS_W'(START_Y);
                r_dir[i] <= DIR_NONE;
            end
        end else begin
            r_done <= 1'b0;
            r_ovr  <= r_busy && move_tick;
            case (r_state)
                ST_IDLE: begin
                    if (move_tick) begin
                        r_g     <= '0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_rd_x  <= w_tx;
                        r_rd_y  <= w_ty;
                        r_cand  <= w_cand;
                        r_tried <= dir_onehot(w_cand);
                        r_state <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (maze.maze_rd_valid) begin
                        r_req   <= 1'b0;
                        r_wall  <= maze.maze_rd_wall;
                        r_state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (!r_wall) begin
                        r_x[r_g]   <= r_rd_x;
                        r_y[r_g]   <= r_rd_y;
                        r_dir[r_g] <= dir_onehot(r_cand);
                        r_state    <= ST_NEXT;
                    end else if (r_tried != 4'b1111) begin
                        r_req   <= 1'b1;
                        r_rd_x  <= w_tx;
                        r_rd_y  <= w_ty;
                        r_cand  <= w_cand;
                        r_tried <= r_tried | dir_onehot(w_cand);
                        r_state <= ST_PROBE;
                    end else begin
                        // Boxed in: ghost keeps its tile and heading.
                        r_state <= ST_NEXT;
                    end
                end
                default: begin  // ST_NEXT
                    if (r_g == LAST_G) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_g     <= w_sel_g;
                        r_req   <= 1'b1;
                        r_rd_x  <= w_tx;
                        r_rd_y  <= w_ty;
                        r_cand  <= w_cand;
                        r_tried <= dir_onehot(w_cand);
                        r_state <= ST_PROBE;
                    end
                end
            endcase
        end
    end

    assign maze.maze_rd_req = r_req;
    assign maze.maze_rd_x   = r_rd_x;
    assign maze.maze_rd_y   = r_rd_y;
    assign busy             = r_busy;
    assign round_done       = r_done;
    assign tick_overrun     = r_ovr;

    generate
        for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_pack
            assign ghost_x[gi*POS_W +: POS_W] = r_x[gi];
            assign ghost_y[gi*POS_W +: POS_W] = r_y[gi];
            assign ghost_dir[gi*4 +: 4]       = r_dir[gi];
        end
    endgenerate
endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler: directed self-checking bench for ghost_scheduler.
// A behavioural maze answers lookups with programmable latency and wall map;
// every open answer pushes the tile the ghost should land on into a scoreboard.
`timescale 1ns/1ps
module tb_ghost_scheduler;
    import ghost_pkg::*;

    localparam int NG = 4;
    localparam int PW = 5;

    typedef struct packed {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
    } pos_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic w_tick = 1'b0;
    always #5 clk = ~clk;

    ghost_scheduler_if #(.POS_W(PW)) m_if ();
    ghost_scheduler_if #(.POS_W(PW)) w_if ();

    logic [NG*PW-1:0] gx, gy, wgx, wgy;
    logic [NG*4-1:0]  gd, wgd;
    logic             busy, rdone, ovr, wbusy, wrdone, wovr;

    ghost_scheduler #(.NUM_GHOSTS(NG), .POS_W(PW), .START_X(8), .START_Y(8),
                      .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .move_tick(tick), .maze(m_if),
        .ghost_x(gx), .ghost_y(gy), .ghost_dir(gd),
        .busy(busy), .round_done(rdone), .tick_overrun(ovr)
    );

    ghost_scheduler #(.NUM_GHOSTS(NG), .POS_W(PW), .START_X(31), .START_Y(8),
                      .LFSR_SEED(16'hACE1)) dut_w (
        .clk(clk), .rst(rst), .move_tick(w_tick), .maze(w_if),
        .ghost_x(wgx), .ghost_y(wgy), .ghost_dir(wgd),
        .busy(wbusy), .round_done(wrdone), .tick_overrun(wovr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pos_t step(input pos_t p, input logic [3:0] d);
        pos_t r;
        r = p;
        case (d)
            DIR_UP:    r.y = p.y - 5'd1;
            DIR_DOWN:  r.y = p.y + 5'd1;
            DIR_LEFT:  r.x = p.x - 5'd1;
            DIR_RIGHT: r.x = p.x + 5'd1;
            default:   r = p;
        endcase
        return r;
    endfunction

    // ---------------- behavioural maze for the main DUT ----------------
    int   lat = 1;
    int   mode = 0;           // 0 = all open, 1 = all wall
    int   cnt = 0;
    int   req_count = 0;
    int   rd_pulses = 0;
    pos_t hold;
    pos_t exp_q[$];

    initial begin
        m_if.maze_rd_valid = 1'b0;
        m_if.maze_rd_wall  = 1'b0;
        w_if.maze_rd_valid = 1'b0;
        w_if.maze_rd_wall  = 1'b0;
    end

    always @(negedge clk) begin
        if (m_if.maze_rd_req) begin
            if (cnt == 0) begin
                hold.x = m_if.maze_rd_x;
                hold.y = m_if.maze_rd_y;
                req_count++;
            end else begin
                checks++;
                assert (m_if.maze_rd_x === hold.x && m_if.maze_rd_y === hold.y) else begin
                    errors++;
                    $error("FAIL addr_stable observed=%0d,%0d expected=%0d,%0d",
                           m_if.maze_rd_x, m_if.maze_rd_y, hold.x, hold.y);
                end
            end
            cnt++;
            if (cnt == lat + 1) begin
                m_if.maze_rd_valid = 1'b1;
                m_if.maze_rd_wall  = (mode == 1);
                $display("lookup x=%0d y=%0d wall=%0d", hold.x, hold.y, (mode == 1));
                if (mode != 1) exp_q.push_back(hold);
            end else begin
                m_if.maze_rd_valid = 1'b0;
            end
        end else begin
            cnt = 0;
            m_if.maze_rd_valid = 1'b0;
            m_if.maze_rd_wall  = 1'b0;
        end
        if (rdone) rd_pulses++;
    end

    // Wrap maze: only tile (0,8) is open, answers in the request cycle.
    always @(negedge clk) begin
        w_if.maze_rd_valid = w_if.maze_rd_req;
        w_if.maze_rd_wall  = !(w_if.maze_rd_x == 5'd0 && w_if.maze_rd_y == 5'd8);
    end

    task automatic send_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    // Called at the negedge of cycle T+start; returns k with round_done seen in T+k.
    task automatic wait_done(input int start, output int k);
        k = start;
        while (!rdone && k < start + 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        pos_t       prev [NG];
        logic [3:0] pdir [NG];
        pos_t       e, a;
        logic [3:0] d;
        int         k;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---- reset state ----
        chk("rst_busy", busy, 0);
        chk("rst_req", m_if.maze_rd_req, 0);
        chk("rst_done", rdone, 0);
        for (int g = 0; g < NG; g++) begin
            chk("rst_x", gx[g*PW +: PW], 8);
            chk("rst_y", gy[g*PW +: PW], 8);
            chk("rst_dir", gd[g*4 +: 4], 0);
            chk("rst_wrap_x", wgx[g*PW +: PW], 31);
        end

        // ---- open maze, 1-cycle latency ----
        mode = 0; lat = 1; req_count = 0; rd_pulses = 0; exp_q.delete();
        send_tick();
        wait_done(1, k);
        chk("open_latency", k, 17);
        @(negedge clk);
        chk("open_done_pulse", rdone, 0);
        chk("open_busy", busy, 0);
        chk("open_reqs", req_count, 4);
        chk("open_done_count", rd_pulses, 1);
        chk("open_q", exp_q.size(), 4);
        for (int g = 0; g < NG; g++) begin
            a.x = gx[g*PW +: PW];
            a.y = gy[g*PW +: PW];
            d   = gd[g*4 +: 4];
            chk("open_onehot", {31'd0, $onehot(d)}, 1);
            e.x = 5'd8; e.y = 5'd8;
            chk("open_step", a, step(e, d));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("open_sb", a, e);
            end
            prev[g] = a;
            pdir[g] = d;
        end

        // ---- latency stretch: ghosts keep heading in an open maze ----
        lat = 5; req_count = 0; exp_q.delete();
        send_tick();
        wait_done(1, k);
        chk("stretch_timeout", rdone, 1);
        @(negedge clk);
        chk("stretch_reqs", req_count, 4);
        for (int g = 0; g < NG; g++) begin
            a.x = gx[g*PW +: PW];
            a.y = gy[g*PW +: PW];
            chk("stretch_pos", a, step(prev[g], pdir[g]));
            chk("stretch_dir", gd[g*4 +: 4], pdir[g]);
        end

        // ---- asynchronous reset mid-round with req high ----
        send_tick();
        chk("mid_req_high", m_if.maze_rd_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", m_if.maze_rd_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", {m_if.maze_rd_x, m_if.maze_rd_y}, 0);
        for (int g = 0; g < NG; g++) begin
            chk("arst_x", gx[g*PW +: PW], 8);
            chk("arst_y", gy[g*PW +: PW], 8);
            chk("arst_dir", gd[g*4 +: 4], 0);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // ---- all-wall maze ----
        mode = 1; lat = 1; req_count = 0; rd_pulses = 0; exp_q.delete();
        send_tick();
        wait_done(1, k);
        chk("wall_latency", k, 53);
        repeat (4) @(negedge clk);
        chk("wall_reqs", req_count, 16);
        chk("wall_done_count", rd_pulses, 1);
        for (int g = 0; g < NG; g++) begin
            chk("wall_x", gx[g*PW +: PW], 8);
            chk("wall_y", gy[g*PW +: PW], 8);
            chk("wall_dir", gd[g*4 +: 4], 0);
        end

        // ---- overrun: second tick at T+3 ----
        mode = 0; lat = 1; req_count = 0; rd_pulses = 0; exp_q.delete();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("ovr_pulse", ovr, 1);
        @(negedge clk);
        chk("ovr_pulse_end", ovr, 0);
        wait_done(5, k);
        chk("ovr_latency", k, 17);
        repeat (20) @(negedge clk);
        chk("ovr_done_count", rd_pulses, 1);
        chk("ovr_reqs", req_count, 4);
        for (int g = 0; g < NG; g++) begin
            a.x = gx[g*PW +: PW];
            a.y = gy[g*PW +: PW];
            e.x = 5'd8; e.y = 5'd8;
            chk("ovr_step", a, step(e, gd[g*4 +: 4]));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ovr_sb", a, e);
            end
        end

        // ---- wrap: start x=31, only RIGHT neighbour (0,8) open ----
        @(negedge clk); w_tick = 1'b1;
        @(negedge clk); w_tick = 1'b0;
        k = 0;
        while (!wrdone && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_timeout", wrdone, 1);
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            $display("wrap ghost %0d x=%0d y=%0d dir=%b", g, wgx[g*PW +: PW],
                     wgy[g*PW +: PW], wgd[g*4 +: 4]);
            chk("wrap_x", wgx[g*PW +: PW], 0);
            chk("wrap_y", wgy[g*PW +: PW], 8);
            chk("wrap_dir", wgd[g*4 +: 4], 4'b1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghost_scheduler.md
# ghost_scheduler

Sequences movement of all ghosts once per game move tick, sharing a single maze wall-lookup read port among them. For each ghost in turn it probes the tile ahead in the current direction, picks an alternative pseudo-random direction on a wall, and commits a one-tile step. It sits between the game tick generator and the maze ROM arbiter, and feeds ghost positions to the renderer and collision logic.

## Interface

- NUM_GHOSTS, 4, number of ghosts sequenced per round
- POS_W, 5, coordinate width; grid is 2^POS_W × 2^POS_W
- START_X, 8, reset/start x of every ghost
- START_Y, 8, reset/start y of every ghost
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- move_tick  in  1  one-cycle pulse; starts a movement round
- maze_rd_req  out  1  wall lookup request
- maze_rd_x  out  POS_W  lookup x
- maze_rd_y  out  POS_W  lookup y
- maze_rd_valid  in  1  lookup result valid
- maze_rd_wall  in  1  1 = tile is a wall; qualified by maze_rd_valid
- ghost_x  out  NUM_GHOSTS*POS_W  packed x; ghost i at bits [i*POS_W +: POS_W]
- ghost_y  out  NUM_GHOSTS*POS_W  packed y
- ghost_dir  out  NUM_GHOSTS*4  packed one-hot direction: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000, 0000 = none
- busy  out  1  round in progress
- round_done  out  1  one-cycle pulse after the last ghost commits
- tick_overrun  out  1  one-cycle pulse when move_tick arrives while busy

## Operation

- FSM states: IDLE, PROBE, DECIDE, NEXT.
- IDLE: on move_tick, set ghost index g=0, busy=1, and go to PROBE.
- Candidate selection per ghost, at most 4 distinct candidates. The first candidate is the current dir. If dir=0000, the first candidate comes from the LFSR. Further candidates rotate through UP, DOWN, LEFT, RIGHT starting at LFSR[1:0], skipping directions already tried.
- PROBE: drive req=1 with the target tile, which is the position ±1 along the candidate direction, wrapping mod 2^POS_W. Hold req and the address stable until valid is sampled high, then go to DECIDE.
- DECIDE:
  - wall=0: commit the step to the target position, set dir to the candidate, go to NEXT.
  - wall=1 with candidates remaining: go back to PROBE with the next candidate.
  - wall=1 with all 4 tried: position unchanged, dir unchanged, go to NEXT.
- NEXT: if g=NUM_GHOSTS-1, pulse round_done, set busy=0, go to IDLE. Otherwise g++ and go to PROBE.
- move_tick while busy: dropped, and tick_overrun pulses. The current round is unaffected.
- maze_rd_valid is ignored while req=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It is free-running and advances every clock.
- Async reset, asserted at any point including mid-round:
  - FSM to IDLE.
  - ghost_x=START_X and ghost_y=START_Y for all ghosts.
  - ghost_dir=0.
  - busy, round_done, tick_overrun, maze_rd_req = 0.
  - maze_rd_x/y = 0.
  - LFSR = LFSR_SEED.

## Timing

- All outputs are registered.
- Worked example, with move_tick sampled at cycle T and a lookup that returns valid 1 cycle after req:
  - T+1: req high.
  - T+2: valid.
  - T+3: DECIDE.
  - T+4: new position visible.
- Best case per ghost: 4 cycles (PROBE, wait, DECIDE, NEXT). Each extra candidate adds PROBE + wait + DECIDE.
- req deasserts the cycle after valid is sampled. req is never high in IDLE, DECIDE or NEXT.
- round_done is high in the cycle after the final NEXT. busy falls in that same cycle.
- Each ghost's position and dir change only at its own DECIDE edge. Other ghosts hold their values.

## Structure

- Shared package ghost_pkg holds:
  - direction one-hot constants;
  - the state enum;
  - the default POS_W, START_X and START_Y;
  - the LFSR width and taps, also used by the renderer and pellet logic.
- Sub-module ghost_lfsr: 16-bit LFSR with seed parameter, enable tied high here.

## Test plan

- Reset: drive rst=0 mid-round, with req high. Required: req falls asynchronously; every ghost reads (8,8) with dir=0000; busy=0.
- Open maze, valid at 1-cycle latency, one tick. Required: each ghost moves exactly 1 tile in a single axis with nonzero one-hot dir; 4 req pulses total; round_done at T+17.
- All-wall maze, one tick. Required: 16 lookups; all positions stay (8,8); dir stays 0000; round_done pulses once.
- Wrap: START_X=31, with only the RIGHT neighbour open. Required: after a tick, every ghost is at x=0, y=8, dir=1000.
- Latency stretch: valid delayed 5 cycles. Required: maze_rd_x/y and req stay constant for all 5 cycles; committed position matches an undelayed run.
- Overrun: second move_tick at T+3. Required: tick_overrun pulses at T+4; each ghost steps exactly once; a single round_done.
